// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits. Scans one digit per SCAN_DIV-cycle slot, blanks the
// first BLANK_CYCLES of every slot, supports per-digit DP, digit enables and
// leading-zero suppression, and swaps in new values only at frame boundaries.
module seg7_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 50000,
    parameter int BLANK_CYCLES     = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PS_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [PS_W-1:0]       PS_BLANK = PS_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ANODE_ACTIVE_LOW != 0) ?
                                                 {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Hex nibble to active-low segment pattern {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [PS_W-1:0]         prescaler_r;
    logic [IDX_W-1:0]        index_r;
    logic [4*NUM_DIGITS-1:0] pending_r;
    logic [4*NUM_DIGITS-1:0] display_r;
    logic [7:0]              seg_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_done_r;

    logic                    slot_last_s;
    logic                    boundary_s;
    logic                    blank_phase_s;
    logic                    zero_run_s;
    logic [NUM_DIGITS-1:0]   zero_from_s;
    logic [3:0]              nib_sel_s;
    logic                    dp_sel_s;
    logic                    en_sel_s;
    logic                    suppress_s;
    logic [NUM_DIGITS-1:0]   an_on_s;
    logic [7:0]              seg_next_s;

    // Slot/frame timing decodes from the prescaler and digit index.
    always_comb begin
        slot_last_s   = (prescaler_r == PS_LAST);
        boundary_s    = slot_last_s && (index_r == IDX_LAST);
        blank_phase_s = (prescaler_r < PS_BLANK);
    end

    // zero_from_s[k] is set when display nibbles k..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_run_s  = 1'b1;
        zero_from_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s     = zero_run_s & (display_r[4*k +: 4] == 4'h0);
            zero_from_s[k] = zero_run_s;
        end
    end

    // Per-slot selection of the current digit's nibble, DP, enable and suppression.
    always_comb begin
        nib_sel_s  = display_r[{index_r, 2'b00} +: 4];
        dp_sel_s   = dp_mask[index_r];
        en_sel_s   = digit_en[index_r];
        suppress_s = lz_blank && (index_r != {IDX_W{1'b0}}) && zero_from_s[index_r];
    end

    // Next anode pattern (active-high form) and next segment pattern.
    always_comb begin
        an_on_s = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_on_s[k] = (index_r == IDX_W'(k)) && en_sel_s && !blank_phase_s;
        end
        if (blank_phase_s || !en_sel_s) begin
            seg_next_s = 8'hFF;
        end else if (suppress_s) begin
            seg_next_s = {~dp_sel_s, 7'h7F};
        end else begin
            seg_next_s = {~dp_sel_s, hex_glyph(nib_sel_s)};
        end
    end

    // Scan counters, pending/display value registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r  <= {PS_W{1'b0}};
            index_r      <= {IDX_W{1'b0}};
            pending_r    <= {(4*NUM_DIGITS){1'b0}};
            display_r    <= {(4*NUM_DIGITS){1'b0}};
            seg_r        <= 8'hFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            if (slot_last_s) begin
                prescaler_r <= {PS_W{1'b0}};
                index_r     <= (index_r == IDX_LAST) ? {IDX_W{1'b0}} : index_r + IDX_W'(1);
            end else begin
                prescaler_r <= prescaler_r + PS_W'(1);
                index_r     <= index_r;
            end
            if (load) begin
                pending_r <= value;
            end else begin
                pending_r <= pending_r;
            end
            // A load on the boundary edge bypasses pending straight into display.
            if (boundary_s) begin
                display_r <= load ? value : pending_r;
            end else begin
                display_r <= display_r;
            end
            seg_r        <= seg_next_s;
            an_r         <= (ANODE_ACTIVE_LOW != 0) ? ~an_on_s : an_on_s;
            frame_done_r <= boundary_s;
        end
    end

    assign seg        = seg_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits, generalising the single-digit hex decoder with scanning, per-digit decimal points, digit enables, leading-zero suppression and tear-free frame-synchronous updates. It sits between the CPU's memory-mapped display register and the board's shared segment bus plus per-digit anode lines.

## Interface
- NUM_DIGITS, 4: digits driven; 1..8.
- SCAN_DIV, 50000: clk cycles per digit slot; ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes inactive (anti-ghosting); ≥ 0.
- ANODE_ACTIVE_LOW, 1: 1 = anode lines active-low, 0 = active-high.

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  bit k lights DP of digit k; sampled live.
- digit_en  in  NUM_DIGITS  bit k = 0 keeps digit k dark; sampled live.
- lz_blank  in  1  1 = suppress leading zeros; sampled live.
- load  in  1  one-cycle strobe capturing value into the pending register.
- seg  out  8  active-low segments, bit order {DP,G,F,E,D,C,B,A} (seg[0]=A).
- an  out  NUM_DIGITS  anode selects, polarity per ANODE_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Glyphs (seg[6:0], DP off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E (hex). Blank = FF. DP on clears seg[7].
- Registers: pending (4*NUM_DIGITS), display (4*NUM_DIGITS), prescaler (0..SCAN_DIV-1), index (0..NUM_DIGITS-1).
- load=1: pending <= value the same edge.
- Prescaler counts every cycle; at SCAN_DIV-1 it wraps to 0 and index increments, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = the edge where index wraps to 0: display <= (load ? value : pending); frame_done pulses for one cycle. Display never changes mid-frame.
- Slot phase: prescaler < BLANK_CYCLES -> all anodes inactive, seg=FF. Otherwise the anode for index is active if digit_en[index]=1, else all inactive.
- Leading-zero suppression (lz_blank=1): digit k>0 is blank if display nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. DP on a suppressed digit still follows dp_mask.
- Disabled or blank-phase slots still consume full slot time. Frame period = NUM_DIGITS*SCAN_DIV cycles.
- NUM_DIGITS=1: index is constant 0; the boundary occurs every SCAN_DIV cycles.

## Timing
- seg, an and frame_done are registered. Their values at edge t+1 reflect the prescaler, index, display and live inputs at edge t (1-cycle latency).
- Reset, all synchronous: prescaler=0, index=0, pending=0, display=0, seg=FF, an=all inactive, frame_done=0.
- The first anode assertion after reset release occurs BLANK_CYCLES+1 edges later.
- Reset asserted mid-frame returns all state to reset values on the next edge. A load coincident with reset is discarded.
- Simultaneous load and frame boundary: the new value reaches display directly, and pending also takes it.
- Multiple loads within one frame: the last one wins.
- Live inputs (dp_mask, digit_en, lz_blank) take effect on the next edge, even mid-slot.

## Test plan
Configuration for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1.

- Reset held 3 cycles then released -> seg=FF and an=F throughout reset. First active slot: an=E, seg=C0. frame_done first pulses 32 cycles after release.
- load value=12AF, dp_mask=0, lz_blank=0; check the frame after the boundary -> digit0 seg=8E/an=E, digit1 88/D, digit2 A4/B, digit3 F9/7. Each digit is lit 6 of 8 cycles, with 2 blank cycles (an=F, seg=FF).
- dp_mask=0001 with value=12AF -> digit0 seg=0E; other digits unchanged. dp_mask=1000 with lz_blank=1 and value=0005 -> digit3 seg=7F, digit0 seg=92, digits 1 and 2 seg=FF.
- lz_blank=1, value=0030 -> digit3 FF, digit2 FF, digit1 B0, digit0 C0. With value=0000: digit0 C0, all others FF.
- load=1234 mid-frame, then load=5678 in the same frame, then load=9ABC exactly on the boundary edge -> the display shows 9ABC from the next frame. 1234 and 5678 are never displayed.
- digit_en=0101 -> an stays F during slots 1 and 3, and frame period stays 32 cycles. Reset asserted during slot 2 -> an=F and seg=FF next edge, then scanning restarts at digit 0 with display=0000.
